cmd_seq_mc: RTL and testbench

- Next-generation command sequencer: a multi-channel, single-clock successor to the serial command sequencer.
- Holds a bit pattern in byte memory, written over the 8-bit register bus.
- Shifts the pattern out MSB-first on up to 8 masked output channels.
- Supports a programmable repeat count (including infinite), programmable idle gap between repetitions, explicit stop, and bounds-checked memory access.

---
 rtl/cmd_seq_mc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cmd_seq_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_seq_mc.sv
// Multi-channel command sequencer: shifts a byte-memory bit pattern MSB-first onto masked CMD_DATA lines.
// Optional external start input is enabled by defining CMD_SEQ_MC_EXT_START_EN.
module cmd_seq_mc #(
  parameter int MEM_BYTES = 2048,
  parameter int CHANNELS  = 4,
  parameter int ABUSWIDTH = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 CMD_EXT_START,
  output logic [CHANNELS-1:0]  CMD_DATA,
  output logic                 CMD_READY,
  output logic                 CMD_START_FLAG
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  logic [7:0]          mem [MEM_BYTES];
  logic [31:0]         add32;
  logic                in_mem;
  logic [AW-1:0]       mem_addr;
  logic                wr_soft, wr_start, wr_stop;
  logic                ext_en, ext_edge;
  logic [7:0]          rd_data;

  logic [CHANNELS-1:0] mask_reg, mask_l;
  logic [15:0]         size_reg, size_l;
  logic [15:0]         repeat_reg, repeat_l;
  logic [15:0]         gap_reg, gap_l;

  state_t              state, state_n;
  logic [15:0]         bit_idx, idx_n;
  logic [15:0]         rep_cnt, rep_n;
  logic [15:0]         gap_cnt, gap_n;
  logic                first, first_n;
  logic                start_req, load;
  logic [CHANNELS-1:0] data_n;
  logic                flag_n, ready_n;
  logic [7:0]          cur_byte;
  logic                cur_bit;
  logic                last_rep;
  logic                unused_ok;

  assign add32    = 32'(BUS_ADD);
  assign in_mem   = (add32 >= 32'd16) && (add32 < 32'(16 + MEM_BYTES));
  assign mem_addr = AW'(add32 - 32'd16);
  assign wr_soft  = BUS_WR && (add32 == 32'd0);
  assign wr_start = BUS_WR && (add32 == 32'd1);
  assign wr_stop  = BUS_WR && (add32 == 32'd9);
  assign unused_ok = &{1'b0, BUS_RD, CMD_EXT_START, add32};

`ifdef CMD_SEQ_MC_EXT_START_EN
  logic       conf_ext;
  logic [2:0] ext_sync;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      ext_sync <= '0;
    end else begin
      ext_sync <= {ext_sync[1:0], CMD_EXT_START};
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      conf_ext <= 1'b0;
    end else if (wr_soft) begin
      conf_ext <= 1'b0;
    end else if (BUS_WR && add32 == 32'd10) begin
      conf_ext <= BUS_DATA_IN[0];
    end
  end

  assign ext_en   = conf_ext;
  assign ext_edge = ext_sync[1] & ~ext_sync[2];
`else
  assign ext_en   = 1'b0;
  assign ext_edge = 1'b0;
`endif

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      mask_reg   <= {CHANNELS{1'b1}};
      size_reg   <= 16'd0;
      repeat_reg <= 16'd1;
      gap_reg    <= 16'd0;
    end else if (wr_soft) begin
      mask_reg   <= {CHANNELS{1'b1}};
      size_reg   <= 16'd0;
      repeat_reg <= 16'd1;
      gap_reg    <= 16'd0;
    end else if (BUS_WR) begin
      case (add32)
        32'd2:   mask_reg         <= BUS_DATA_IN[CHANNELS-1:0];
        32'd3:   size_reg[7:0]    <= BUS_DATA_IN;
        32'd4:   size_reg[15:8]   <= BUS_DATA_IN;
        32'd5:   repeat_reg[7:0]  <= BUS_DATA_IN;
        32'd6:   repeat_reg[15:8] <= BUS_DATA_IN;
        32'd7:   gap_reg[7:0]     <= BUS_DATA_IN;
        32'd8:   gap_reg[15:8]    <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  // Pattern memory survives both resets.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_WR && in_mem) begin
      mem[mem_addr] <= BUS_DATA_IN;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (in_mem) begin
      rd_data = mem[mem_addr];
    end else begin
      case (add32)
        32'd0:   rd_data = 8'h02;
        32'd1:   rd_data = {7'd0, CMD_READY};
        32'd2:   rd_data = 8'(mask_reg);
        32'd3:   rd_data = size_reg[7:0];
        32'd4:   rd_data = size_reg[15:8];
        32'd5:   rd_data = repeat_reg[7:0];
        32'd6:   rd_data = repeat_reg[15:8];
        32'd7:   rd_data = gap_reg[7:0];
        32'd8:   rd_data = gap_reg[15:8];
        32'd9:   rd_data = {7'd0, ext_en};
        32'd10:  rd_data = {7'd0, ext_en};
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      BUS_DATA_OUT <= 8'h00;
      start_req    <= 1'b0;
    end else if (wr_soft) begin
      BUS_DATA_OUT <= 8'h00;
      start_req    <= 1'b0;
    end else begin
      BUS_DATA_OUT <= rd_data;
      start_req    <= wr_start | (ext_en & ext_edge);
    end
  end

  // Bit index wraps naturally because only the low address bits select the byte.
  assign cur_byte = mem[AW'(bit_idx >> 3)];
  assign cur_bit  = cur_byte[3'd7 - bit_idx[2:0]];
  assign last_rep = (repeat_l != 16'd0) && (rep_cnt >= repeat_l - 16'd1);

  always_comb begin
    state_n = state;
    idx_n   = bit_idx;
    rep_n   = rep_cnt;
    gap_n   = gap_cnt;
    first_n = first;
    data_n  = '0;
    flag_n  = 1'b0;
    ready_n = 1'b0;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (start_req && size_reg != 16'd0) begin
          state_n = ST_SEND;
          idx_n   = 16'd0;
          rep_n   = 16'd0;
          first_n = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        data_n  = {CHANNELS{cur_bit}} & mask_l;
        flag_n  = first;
        first_n = 1'b0;
        if (bit_idx == size_l - 16'd1) begin
          idx_n = 16'd0;
          if (last_rep) begin
            state_n = ST_IDLE;
          end else begin
            if (rep_cnt != 16'hFFFF) rep_n = rep_cnt + 16'd1;
            if (gap_l != 16'd0) begin
              state_n = ST_GAP;
              gap_n   = 16'd0;
            end
          end
        end else begin
          idx_n = bit_idx + 16'd1;
        end
      end
      ST_GAP: begin
        gap_n = gap_cnt + 16'd1;
        if (gap_cnt == gap_l - 16'd1) state_n = ST_SEND;
      end
      default: state_n = ST_IDLE;
    endcase
    if (wr_stop && state != ST_IDLE) begin
      state_n = ST_IDLE;
      data_n  = '0;
      flag_n  = 1'b0;
      ready_n = 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      mask_l   <= {CHANNELS{1'b1}};
      size_l   <= 16'd0;
      repeat_l <= 16'd1;
      gap_l    <= 16'd0;
    end else if (wr_soft) begin
      mask_l   <= {CHANNELS{1'b1}};
      size_l   <= 16'd0;
      repeat_l <= 16'd1;
      gap_l    <= 16'd0;
    end else if (load) begin
      mask_l   <= mask_reg;
      size_l   <= size_reg;
      repeat_l <= repeat_reg;
      gap_l    <= gap_reg;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state          <= ST_IDLE;
      bit_idx        <= 16'd0;
      rep_cnt        <= 16'd0;
      gap_cnt        <= 16'd0;
      first          <= 1'b0;
      CMD_DATA       <= '0;
      CMD_START_FLAG <= 1'b0;
      CMD_READY      <= 1'b1;
    end else if (wr_soft) begin
      state          <= ST_IDLE;
      bit_idx        <= 16'd0;
      rep_cnt        <= 16'd0;
      gap_cnt        <= 16'd0;
      first          <= 1'b0;
      CMD_DATA       <= '0;
      CMD_START_FLAG <= 1'b0;
      CMD_READY      <= 1'b1;
    end else begin
      state          <= state_n;
      bit_idx        <= idx_n;
      rep_cnt        <= rep_n;
      gap_cnt        <= gap_n;
      first          <= first_n;
      CMD_DATA       <= data_n;
      CMD_START_FLAG <= flag_n;
      CMD_READY      <= ready_n;
    end
  end

endmodule

// File: tb/tb_cmd_seq_mc.sv
// Directed bench for cmd_seq_mc: register/memory vector table plus hand-written output sequences.
module tb_cmd_seq_mc;

  localparam int MEM_BYTES = 2048;
  localparam int CHANNELS  = 4;
  localparam int ABUSWIDTH = 16;

  logic                 BUS_CLK = 1'b0;
  logic                 BUS_RST_N;
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic                 BUS_WR;
  logic                 BUS_RD;
  logic [7:0]           BUS_DATA_OUT;
  logic                 CMD_EXT_START;
  logic [CHANNELS-1:0]  CMD_DATA;
  logic                 CMD_READY;
  logic                 CMD_START_FLAG;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_write;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[$];

  cmd_seq_mc #(
    .MEM_BYTES(MEM_BYTES),
    .CHANNELS (CHANNELS),
    .ABUSWIDTH(ABUSWIDTH)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST_N     (BUS_RST_N),
    .BUS_ADD       (BUS_ADD),
    .BUS_DATA_IN   (BUS_DATA_IN),
    .BUS_WR        (BUS_WR),
    .BUS_RD        (BUS_RD),
    .BUS_DATA_OUT  (BUS_DATA_OUT),
    .CMD_EXT_START (CMD_EXT_START),
    .CMD_DATA      (CMD_DATA),
    .CMD_READY     (CMD_READY),
    .CMD_START_FLAG(CMD_START_FLAG)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  function automatic vec_t mkVec(input bit w, input logic [15:0] a, input logic [7:0] d);
    vec_t v;
    v.is_write = w;
    v.addr     = a;
    v.data     = d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    @(negedge BUS_CLK);
    BUS_ADD     = addr;
    BUS_DATA_IN = data;
    BUS_WR      = 1'b1;
    @(posedge BUS_CLK);
    #1;
    BUS_WR = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [7:0] data);
    @(negedge BUS_CLK);
    BUS_ADD = addr;
    BUS_WR  = 1'b0;
    BUS_RD  = 1'b1;
    @(posedge BUS_CLK);
    #1;
    data   = BUS_DATA_OUT;
    BUS_RD = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [15:0] addr, input logic [7:0] expected);
    logic [7:0] rd;
    busRead(addr, rd);
    checkOutput(name, 32'(rd), 32'(expected));
  endtask

  task automatic stepCheck(input string name, input logic [3:0] exp_data, input logic exp_flag,
                           input logic exp_ready);
    @(posedge BUS_CLK);
    #1;
    checkOutput({name, "_data"},  32'(CMD_DATA),       32'(exp_data));
    checkOutput({name, "_flag"},  32'(CMD_START_FLAG), 32'(exp_flag));
    checkOutput({name, "_ready"}, 32'(CMD_READY),      32'(exp_ready));
  endtask

  task automatic setConfig(input logic [15:0] size, input logic [15:0] rep, input logic [15:0] gap,
                           input logic [7:0] mask);
    applyStimulus(16'd3, size[7:0]);
    applyStimulus(16'd4, size[15:8]);
    applyStimulus(16'd5, rep[7:0]);
    applyStimulus(16'd6, rep[15:8]);
    applyStimulus(16'd7, gap[7:0]);
    applyStimulus(16'd8, gap[15:8]);
    applyStimulus(16'd2, mask);
  endtask

  initial begin
    logic [7:0] pat [2];
    logic       exp_bit;
    int         idx;

    BUS_RST_N     = 1'b0;
    BUS_ADD       = '0;
    BUS_DATA_IN   = '0;
    BUS_WR        = 1'b0;
    BUS_RD        = 1'b0;
    CMD_EXT_START = 1'b0;

    // Register and memory map vectors, reads carry the expected value in data.
    vecs.push_back(mkVec(1'b0, 16'd0,    8'h02));
    vecs.push_back(mkVec(1'b0, 16'd1,    8'h01));
    vecs.push_back(mkVec(1'b0, 16'd2,    8'h0F));
    vecs.push_back(mkVec(1'b0, 16'd5,    8'h01));
    vecs.push_back(mkVec(1'b0, 16'd6,    8'h00));
    vecs.push_back(mkVec(1'b0, 16'd3,    8'h00));
    vecs.push_back(mkVec(1'b0, 16'd9,    8'h00));
    vecs.push_back(mkVec(1'b0, 16'd11,   8'h00));
    vecs.push_back(mkVec(1'b1, 16'd2,    8'hFF));
    vecs.push_back(mkVec(1'b0, 16'd2,    8'h0F));
    vecs.push_back(mkVec(1'b1, 16'd7,    8'h34));
    vecs.push_back(mkVec(1'b0, 16'd7,    8'h34));
    vecs.push_back(mkVec(1'b1, 16'd7,    8'h00));
    vecs.push_back(mkVec(1'b1, 16'd10,   8'h01));
    vecs.push_back(mkVec(1'b0, 16'd10,   8'h00));
    vecs.push_back(mkVec(1'b0, 16'd9,    8'h00));
    vecs.push_back(mkVec(1'b1, 16'd16,   8'hA5));
    vecs.push_back(mkVec(1'b0, 16'd16,   8'hA5));
    vecs.push_back(mkVec(1'b1, 16'd2063, 8'h3C));
    vecs.push_back(mkVec(1'b0, 16'd2063, 8'h3C));
    vecs.push_back(mkVec(1'b1, 16'd2064, 8'h77));
    vecs.push_back(mkVec(1'b0, 16'd2064, 8'h00));
    vecs.push_back(mkVec(1'b0, 16'd16,   8'hA5));
    vecs.push_back(mkVec(1'b0, 16'd2063, 8'h3C));
    vecs.push_back(mkVec(1'b1, 16'd13,   8'h55));
    vecs.push_back(mkVec(1'b0, 16'd13,   8'h00));
    vecs.push_back(mkVec(1'b0, 16'hFFFF, 8'h00));

    repeat (3) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    stepCheck("reset", 4'h0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      if (vecs[i].is_write) begin
        applyStimulus(vecs[i].addr, vecs[i].data);
      end else begin
        readCheck($sformatf("vec%0d_rd_%0h", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
      end
    end

    // Single pass of 8'hA5 on channels 0 and 2 only.
    pat[0] = 8'hA5;
    setConfig(16'd8, 16'd1, 16'd0, 8'h05);
    applyStimulus(16'd1, 8'h01);
    stepCheck("a_lat", 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_bit = pat[0][7-i];
      stepCheck($sformatf("a_bit%0d", i), exp_bit ? 4'h5 : 4'h0, i == 0, 1'b0);
    end
    stepCheck("a_done", 4'h0, 1'b0, 1'b1);

    // 12-bit pattern, three repetitions separated by 2-cycle gaps.
    pat[0] = 8'hF0;
    pat[1] = 8'h0F;
    applyStimulus(16'd16, pat[0]);
    applyStimulus(16'd17, pat[1]);
    setConfig(16'd12, 16'd3, 16'd2, 8'h0F);
    applyStimulus(16'd1, 8'h01);
    stepCheck("b_lat", 4'h0, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      idx = c % 14;
      exp_bit = (idx < 12) ? pat[idx >> 3][7 - (idx & 7)] : 1'b0;
      stepCheck($sformatf("b_cyc%0d", c), exp_bit ? 4'hF : 4'h0, c == 0, 1'b0);
    end
    stepCheck("b_done", 4'h0, 1'b0, 1'b1);
    stepCheck("b_idle", 4'h0, 1'b0, 1'b1);

    // Infinite repeat of 1001 without bubbles, then stop.
    pat[0] = 8'h90;
    applyStimulus(16'd16, pat[0]);
    setConfig(16'd4, 16'd0, 16'd0, 8'h0F);
    applyStimulus(16'd1, 8'h01);
    stepCheck("c_lat", 4'h0, 1'b0, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      exp_bit = pat[0][7 - (c % 4)];
      stepCheck("c_stream", exp_bit ? 4'hF : 4'h0, c == 0, 1'b0);
    end
    applyStimulus(16'd9, 8'h00);
    checkOutput("c_stop_data",  32'(CMD_DATA),  32'h0);
    checkOutput("c_stop_ready", 32'(CMD_READY), 32'h1);
    stepCheck("c_after_stop", 4'h0, 1'b0, 1'b1);

    // Start with zero size is ignored; stop while idle has no effect.
    setConfig(16'd0, 16'd1, 16'd0, 8'h0F);
    applyStimulus(16'd1, 8'h01);
    for (int c = 0; c < 4; c++) stepCheck("zero_size", 4'h0, 1'b0, 1'b1);
    applyStimulus(16'd9, 8'h00);
    stepCheck("idle_stop", 4'h0, 1'b0, 1'b1);

    // Soft reset in the middle of a sequence.
    setConfig(16'd16, 16'd0, 16'd0, 8'h0F);
    applyStimulus(16'd1, 8'h01);
    stepCheck("d_lat", 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_bit = pat[0][7-i];
      stepCheck($sformatf("d_bit%0d", i), exp_bit ? 4'hF : 4'h0, i == 0, 1'b0);
    end
    applyStimulus(16'd0, 8'h00);
    checkOutput("d_srst_data",  32'(CMD_DATA),  32'h0);
    checkOutput("d_srst_ready", 32'(CMD_READY), 32'h1);
    readCheck("d_repeat", 16'd5,  8'h01);
    readCheck("d_size",   16'd3,  8'h00);
    readCheck("d_mask",   16'd2,  8'h0F);
    readCheck("d_mem0",   16'd16, 8'h90);
    readCheck("d_mem1",   16'd17, 8'h0F);
    readCheck("d_ready",  16'd1,  8'h01);
    stepCheck("d_idle", 4'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
